// File: rtl/polar_engine_arbiter_if.sv
// polar_engine_arbiter_if: requester, engine, result and statistics signals of the
// shared polar-engine arbiter. The arbiter uses the slave view; the surrounding
// requesters/engine (or a bench) use the master view.
interface polar_engine_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    localparam int unsigned M_W    = 14;
    localparam int unsigned N_W    = 15;
    localparam int unsigned MAG_W  = 16;
    localparam int unsigned ATAN_W = 13;
    localparam int unsigned CNT_W  = 16;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*M_W-1:0]    m_in;
    logic [NUM_REQ*N_W-1:0]    n_in;
    logic [NUM_REQ-1:0]        grant;
    logic                      eng_enable;
    logic [M_W-1:0]            eng_M;
    logic signed [N_W-1:0]     eng_N;
    logic                      eng_valid;
    logic [MAG_W-1:0]          eng_mag;
    logic signed [ATAN_W-1:0]  eng_atan;
    logic                      res_valid;
    logic [ID_W-1:0]           res_id;
    logic [MAG_W-1:0]          res_mag;
    logic signed [ATAN_W-1:0]  res_atan;
    logic                      busy;
    logic                      timeout_err;
    logic [ID_W-1:0]           stat_sel;
    logic [CNT_W-1:0]          stat_count;

    modport slave (
        input  req, m_in, n_in, eng_valid, eng_mag, eng_atan, stat_sel,
        output grant, eng_enable, eng_M, eng_N, res_valid, res_id, res_mag,
               res_atan, busy, timeout_err, stat_count
    );

    modport master (
        output req, m_in, n_in, eng_valid, eng_mag, eng_atan, stat_sel,
        input  grant, eng_enable, eng_M, eng_N, res_valid, res_id, res_mag,
               res_atan, busy, timeout_err, stat_count
    );
endinterface

// File: rtl/polar_engine_arbiter.sv
// polar_engine_arbiter: round-robin sharing of one polar-conversion engine between
// NUM_REQ requesters. Latches the winner's (M, N), pulses the engine enable, waits
// for the result strobe (with a watchdog) and returns the result tagged with the id.
// Optional per-requester completion counters are built when POLAR_ARB_STATS_EN is
// defined; otherwise stat_count reads 0.
module polar_engine_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ID_W    = 2
) (
    input  logic                  clock,
    input  logic                  rst,
    polar_engine_arbiter_if.slave bus
);
    localparam int unsigned M_W    = 14;
    localparam int unsigned N_W    = 15;
    localparam int unsigned MAG_W  = 16;
    localparam int unsigned ATAN_W = 13;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WD_W   = $clog2(TIMEOUT);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [ID_W-1:0]           r_ptr;
    logic [ID_W-1:0]           r_sel;
    logic [WD_W-1:0]           r_wd;
    logic [NUM_REQ-1:0]        r_grant;
    logic                      r_eng_enable;
    logic [M_W-1:0]            r_eng_m;
    logic signed [N_W-1:0]     r_eng_n;
    logic                      r_res_valid;
    logic [ID_W-1:0]           r_res_id;
    logic [MAG_W-1:0]          r_res_mag;
    logic signed [ATAN_W-1:0]  r_res_atan;
    logic                      r_busy;
    logic                      r_timeout_err;

    logic                      w_found;
    logic [ID_W-1:0]           w_win;
    logic [NUM_REQ-1:0]        w_grant;
    logic [M_W-1:0]            w_m_sel;
    logic [N_W-1:0]            w_n_sel;

    // Pick the first requesting index at or above the pointer (wrapping) and its operands.
    always_comb begin : rr_pick
        int unsigned        v_idx;
        logic [NUM_REQ-1:0] v_req_sh;
        w_found  = 1'b0;
        w_win    = '0;
        w_grant  = '0;
        w_m_sel  = '0;
        w_n_sel  = '0;
        v_idx    = 0;
        v_req_sh = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_idx = 32'(r_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            v_req_sh = bus.req >> v_idx;
            if (!w_found && v_req_sh[0]) begin
                w_found = 1'b1;
                w_win   = ID_W'(v_idx);
                w_grant = NUM_REQ'(1) << v_idx;
                w_m_sel = M_W'(bus.m_in >> (v_idx * M_W));
                w_n_sel = N_W'(bus.n_in >> (v_idx * N_W));
            end
        end
    end

    // Transaction FSM: capture -> issue pulse -> wait for result or watchdog expiry.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_sel         <= '0;
            r_wd          <= '0;
            r_grant       <= '0;
            r_eng_enable  <= 1'b0;
            r_eng_m       <= '0;
            r_eng_n       <= '0;
            r_res_valid   <= 1'b0;
            r_res_id      <= '0;
            r_res_mag     <= '0;
            r_res_atan    <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_grant       <= '0;
            r_eng_enable  <= 1'b0;
            r_res_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_eng_m      <= w_m_sel;
                        r_eng_n      <= w_n_sel;
                        r_sel        <= w_win;
                        r_grant      <= w_grant;
                        r_eng_enable <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ptr   <= (r_sel == ID_LAST) ? '0 : r_sel + ID_W'(1);
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A strobe on the final watchdog cycle still counts as a result.
                    if (bus.eng_valid) begin
                        r_res_mag   <= bus.eng_mag;
                        r_res_atan  <= bus.eng_atan;
                        r_res_id    <= r_sel;
                        r_res_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (r_wd == WD_LAST) begin
                        r_res_id      <= r_sel;
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.eng_enable  = r_eng_enable;
    assign bus.eng_M       = r_eng_m;
    assign bus.eng_N       = r_eng_n;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_id      = r_res_id;
    assign bus.res_mag     = r_res_mag;
    assign bus.res_atan    = r_res_atan;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;

`ifdef POLAR_ARB_STATS_EN
    logic                     w_done;
    logic [NUM_REQ*CNT_W-1:0] w_cnt_flat;
    logic [CNT_W-1:0]         w_stat;

    assign w_done = (r_state == S_WAIT) && bus.eng_valid;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;

        // Saturating completion counter for requester gi.
        always_ff @(posedge clock) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_done && (r_sel == ID_W'(gi)) && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_cnt_flat[gi*CNT_W +: CNT_W] = r_cnt;
    end

    // Combinational readout; selects beyond the last requester read 0.
    always_comb begin
        w_stat = '0;
        if (32'(bus.stat_sel) < NUM_REQ) begin
            w_stat = CNT_W'(w_cnt_flat >> (32'(bus.stat_sel) * CNT_W));
        end
    end

    assign bus.stat_count = w_stat;
`else
    logic w_stat_sel_unused;

    assign w_stat_sel_unused = ^bus.stat_sel;
    assign bus.stat_count    = '0;
`endif

endmodule

// File: tb/tb_polar_engine_arbiter.sv
// tb_polar_engine_arbiter: scoreboard bench. Stimulus computes the expected issue
// and result of every transaction from a round-robin reference model and queues
// them; a monitor pops and compares whenever the arbiter issues or reports.
`timescale 1ns/1ps
module tb_polar_engine_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TIMEOUT = 64;
`ifdef POLAR_ARB_STATS_EN
    localparam int unsigned ID_W = 3;
`else
    localparam int unsigned ID_W = 2;
`endif

    typedef struct {
        logic [NUM_REQ-1:0] grant;
        logic [13:0]        m;
        logic [14:0]        n;
    } iss_t;

    typedef struct {
        bit          tmo;
        int unsigned id;
        logic [15:0] mag;
        logic [12:0] atan;
        int          dly;
    } res_t;

    typedef struct {
        int          lat;
        logic [15:0] mag;
        logic [12:0] atan;
    } eng_t;

    logic clock;
    logic rst;

    polar_engine_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    polar_engine_arbiter #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT(TIMEOUT),
        .ID_W   (ID_W)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e_cyc  = 0;
    bit eng_busy = 1'b0;

    iss_t q_iss[$];
    res_t q_res[$];
    eng_t q_eng[$];

    // reference model state
    int unsigned m_ptr = 0;
    logic [15:0] m_mag = '0;
    logic [12:0] m_atan = '0;
    int unsigned m_cnt[NUM_REQ];
    logic [13:0] m_op[NUM_REQ];
    logic [14:0] n_op[NUM_REQ];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic int unsigned rr_pick(input logic [NUM_REQ-1:0] r);
        logic [NUM_REQ-1:0] sh;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sh = r >> ((m_ptr + k) % NUM_REQ);
            if (sh[0]) return (m_ptr + k) % NUM_REQ;
        end
        return 0;
    endfunction

    // Queue the expected issue, engine behaviour and outcome of one arbitration.
    task automatic plan(input logic [NUM_REQ-1:0] r, input int lat, input logic [15:0] mag,
                        input logic [12:0] atan, input bit exp_res);
        int unsigned w;
        iss_t i;
        eng_t e;
        res_t x;
        w = rr_pick(r);
        i.grant = NUM_REQ'(1) << w;
        i.m = m_op[w];
        i.n = n_op[w];
        q_iss.push_back(i);
        e.lat = lat;
        e.mag = mag;
        e.atan = atan;
        q_eng.push_back(e);
        m_ptr = (w + 1) % NUM_REQ;
        if (exp_res) begin
            x.id = w;
            if (lat >= 1 && lat <= int'(TIMEOUT)) begin
                x.tmo = 1'b0;
                x.mag = mag;
                x.atan = atan;
                x.dly = lat + 1;
                m_mag = mag;
                m_atan = atan;
                if (m_cnt[w] < 65535) m_cnt[w]++;
            end else begin
                x.tmo = 1'b1;
                x.mag = m_mag;
                x.atan = m_atan;
                x.dly = int'(TIMEOUT) + 1;
            end
            q_res.push_back(x);
        end
    endtask

    task automatic apply_ops();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            bus.m_in[i*14 +: 14] = m_op[i];
            bus.n_in[i*15 +: 15] = n_op[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            m_op[i] = 14'($urandom);
            n_op[i] = 15'($urandom);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (!bus.busy && !eng_busy && !bus.eng_enable) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("wait_idle", "arbiter never returned to idle");
    endtask

    // One request pattern, dropped once the grant is seen.
    task automatic do_txn(input logic [NUM_REQ-1:0] r, input int lat, input logic [15:0] mag,
                          input logic [12:0] atan, input bit exp_res);
        int n;
        wait_idle();
        apply_ops();
        bus.req = r;
        plan(r, lat, mag, atan, exp_res);
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (bus.eng_enable) begin
                n = k;
                break;
            end
        end
        chk("issue_latency", 32'(n), 32'd1);
        bus.req = '0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
        chk({tag, "_eng_enable"}, 32'(bus.eng_enable), 32'd0);
        chk({tag, "_eng_M"}, 32'(bus.eng_M), 32'd0);
        chk({tag, "_eng_N"}, 32'($unsigned(bus.eng_N)), 32'd0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_id"}, 32'(bus.res_id), 32'd0);
        chk({tag, "_res_mag"}, 32'(bus.res_mag), 32'd0);
        chk({tag, "_res_atan"}, 32'($unsigned(bus.res_atan)), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
    endtask

    task automatic check_stats();
        logic [31:0] exp;
        for (int s = 0; s < (1 << ID_W); s++) begin
            @(negedge clock);
            bus.stat_sel = ID_W'(s);
            #1;
            exp = 32'd0;
`ifdef POLAR_ARB_STATS_EN
            if (s < int'(NUM_REQ)) exp = 32'(m_cnt[s]);
`endif
            chk($sformatf("stat_count[%0d]", s), 32'(bus.stat_count), exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_mag = '0;
        m_atan = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) m_cnt[i] = 0;
    endtask

    // Engine model: replies lat cycles after the enable pulse (lat 0 = never).
    initial begin
        eng_t e;
        bus.eng_valid = 1'b0;
        bus.eng_mag   = '0;
        bus.eng_atan  = '0;
        forever begin
            @(negedge clock);
            if (bus.eng_enable && !rst) begin
                if (q_eng.size() == 0) begin
                    fail("engine_plan", "enable with no planned engine response");
                end else begin
                    e = q_eng.pop_front();
                    if (e.lat > 0) begin
                        eng_busy = 1'b1;
                        repeat (e.lat) @(negedge clock);
                        bus.eng_valid = 1'b1;
                        bus.eng_mag   = e.mag;
                        bus.eng_atan  = e.atan;
                        @(negedge clock);
                        bus.eng_valid = 1'b0;
                        bus.eng_mag   = 16'($urandom);
                        bus.eng_atan  = 13'($urandom);
                        eng_busy = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compare every issue and every result/timeout against the queues.
    always @(negedge clock) begin
        iss_t i;
        res_t x;
        if (!rst) begin
            if (bus.eng_enable) begin
                if (q_iss.size() == 0) begin
                    fail("unexpected_issue", "eng_enable with no expected issue");
                end else begin
                    i = q_iss.pop_front();
                    chk("grant", 32'(bus.grant), 32'(i.grant));
                    chk("eng_M", 32'(bus.eng_M), 32'(i.m));
                    chk("eng_N", 32'($unsigned(bus.eng_N)), 32'(i.n));
                    chk("busy_issue", 32'(bus.busy), 32'd1);
                end
                e_cyc = cyc;
            end else if (bus.grant != '0) begin
                chk("grant_without_enable", 32'(bus.grant), 32'd0);
            end
            if (bus.res_valid || bus.timeout_err) begin
                if (q_res.size() == 0) begin
                    fail("unexpected_result", $sformatf("res_valid=%0b timeout_err=%0b with nothing expected",
                                                      bus.res_valid, bus.timeout_err));
                end else begin
                    x = q_res.pop_front();
                    chk("res_valid", 32'(bus.res_valid), 32'(!x.tmo));
                    chk("timeout_err", 32'(bus.timeout_err), 32'(x.tmo));
                    chk("res_id", 32'(bus.res_id), 32'(x.id));
                    chk("res_mag", 32'(bus.res_mag), 32'(x.mag));
                    chk("res_atan", 32'($unsigned(bus.res_atan)), 32'(x.atan));
                    chk("result_delay", 32'(cyc - e_cyc), 32'(x.dly));
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        logic [NUM_REQ-1:0] r;
        int sel, lat, n_en;
        rst = 1'b1;
        bus.req = '0;
        bus.m_in = '0;
        bus.n_in = '0;
        bus.stat_sel = '0;
        model_reset();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            m_op[i] = '0;
            n_op[i] = '0;
        end
        repeat (3) @(negedge clock);
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clock);
        chk_zero_outputs("post_reset");

        // fairness: all requesting for 8 back-to-back transactions
        rand_ops();
        apply_ops();
        bus.req = '1;
        for (int t = 0; t < 8; t++) plan('1, $urandom_range(2, 15), 16'($urandom), 13'($urandom), 1'b1);
        n_en = 0;
        for (int k = 0; k < 2000 && n_en < 8; k++) begin
            @(negedge clock);
            if (bus.eng_enable) begin
                n_en++;
                if (n_en == 8) bus.req = '0;
            end
        end
        chk("fairness_issues", 32'(n_en), 32'd8);

        // single request with fixed operands and engine reply
        rand_ops();
        m_op[0] = 14'd1000;
        n_op[0] = -15'sd500;
        do_txn(4'b0001, 20, 16'd1118, -13'sd948, 1'b1);
        chk("single_eng_M", 32'(bus.eng_M), 32'd1000);
        chk("single_eng_N", 32'($unsigned(bus.eng_N)), 32'h7E0C);
        wait_idle();
        repeat (3) @(negedge clock);
        chk("hold_res_mag", 32'(bus.res_mag), 32'd1118);
        chk("hold_res_atan", 32'($unsigned(bus.res_atan)), 32'h1C4C);
        chk("hold_res_id", 32'(bus.res_id), 32'd0);
        chk("hold_res_valid", 32'(bus.res_valid), 32'd0);

        // timeout, then normal service
        rand_ops();
        do_txn(4'b0110, 0, '0, '0, 1'b1);
        do_txn(4'b1000, 5, 16'hBEEF, 13'h0ABC, 1'b1);
        // race on the final watchdog cycle, and a reply one cycle too late
        do_txn(4'b0011, int'(TIMEOUT), 16'h1234, 13'h1555, 1'b1);
        do_txn(4'b0101, int'(TIMEOUT) + 1, 16'h4321, 13'h0AAA, 1'b1);
        do_txn(4'b0101, int'(TIMEOUT) - 1, 16'h0F0F, 13'h1F0F, 1'b1);

        // reset while waiting; the late engine strobe must be ignored
        rand_ops();
        do_txn(4'b1010, 12, 16'hDEAD, 13'h0123, 1'b0);
        repeat (4) @(negedge clock);
        rst = 1'b1;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        model_reset();
        chk_zero_outputs("reset_in_wait");
        do_txn(4'b1111, 4, 16'h0042, 13'h0042, 1'b1);

        // three completions for requester 2
        do_txn(4'b0100, 3, 16'd100, 13'd7, 1'b1);
        do_txn(4'b0100, 9, 16'd200, 13'd8, 1'b1);
        do_txn(4'b0100, 1, 16'd300, 13'd9, 1'b1);
        wait_idle();
        check_stats();

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            rand_ops();
            do r = NUM_REQ'($urandom); while (r == '0);
            sel = $urandom_range(0, 9);
            case (sel)
                0:       lat = 0;
                1:       lat = int'(TIMEOUT);
                2:       lat = int'(TIMEOUT) + 1;
                3:       lat = int'(TIMEOUT) - 1;
                default: lat = $urandom_range(1, 25);
            endcase
            do_txn(r, lat, 16'($urandom), 13'($urandom), 1'b1);
        end

        wait_idle();
        repeat (5) @(negedge clock);
        chk("issue_queue_drained", 32'(q_iss.size()), 32'd0);
        chk("result_queue_drained", 32'(q_res.size()), 32'd0);
        check_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
